// File: rtl/sfu_psum_accumulator.sv
// Accumulates per-kij partial-sum blocks from PSUM SRAM lane-wise and writes each output to output SRAM.
// Optional ReLU on the written lanes is enabled by defining SFU_RELU_EN.
module sfu_psum_accumulator #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sfu_start,
    input  logic [7:0]                num_nij,
    input  logic [7:0]                num_kij,
    input  logic [ADDR_W-1:0]         out_base_addr,
    output logic                      psum_rd_en,
    output logic [ADDR_W-1:0]         psum_rd_addr,
    input  logic [col*psum_bw-1:0]    psum_rd_data,
    output logic                      out_wr_en,
    output logic [ADDR_W-1:0]         out_wr_addr,
    output logic [col*psum_bw-1:0]    out_wr_data,
    output logic                      sfu_active,
    output logic                      sfu_done
);

    localparam int DW = col * psum_bw;

    typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, FIN} state_t;

    state_t              state_q, state_d;
    logic [7:0]          nij_q, nij_d, kij_q, kij_d;
    logic [7:0]          o_q, o_d, k_q, k_d;
    logic [ADDR_W-1:0]   obase_q, obase_d, base_q, base_d;
    logic [DW-1:0]       acc_q, acc_d;

    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DW-1:0]       wr_data_q, wr_data_d;
    logic                active_q, active_d, done_q, done_d;

    // Lane-wise signed add; each lane wraps at psum_bw bits.
    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]             r;
        logic signed [psum_bw-1:0] la, lb;
        r = '0;
        for (int i = 0; i < col; i++) begin
            la = a[i*psum_bw +: psum_bw];
            lb = b[i*psum_bw +: psum_bw];
            r[i*psum_bw +: psum_bw] = la + lb;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] activation(input logic [DW-1:0] v);
`ifdef SFU_RELU_EN
        logic [DW-1:0]             r;
        logic signed [psum_bw-1:0] l;
        r = '0;
        for (int i = 0; i < col; i++) begin
            l = v[i*psum_bw +: psum_bw];
            r[i*psum_bw +: psum_bw] = (l < 0) ? '0 : l;
        end
        return r;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        nij_d     = nij_q;
        kij_d     = kij_q;
        obase_d   = obase_q;
        o_d       = o_q;
        k_d       = k_q;
        base_d    = base_q;
        acc_d     = acc_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_q)
            IDLE: begin
                if (sfu_start) begin
                    nij_d   = num_nij;
                    kij_d   = num_kij;
                    obase_d = out_base_addr;
                    o_d     = '0;
                    k_d     = '0;
                    base_d  = '0;
                    acc_d   = '0;
                    if (num_nij != 8'd0 && num_kij != 8'd0) begin
                        state_d = RD;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD: begin
                // Data on psum_rd_data belongs to the read issued last cycle, if any.
                if (k_q != 8'd0) acc_d = lane_add(acc_q, psum_rd_data);
                if (k_q == kij_q - 8'd1) begin
                    state_d = DRAIN;
                end else begin
                    k_d       = k_q + 8'd1;
                    base_d    = base_q + ADDR_W'(nij_q);
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_d + ADDR_W'(o_q);
                end
            end
            DRAIN: begin
                acc_d     = lane_add(acc_q, psum_rd_data);
                state_d   = WR;
                wr_en_d   = 1'b1;
                wr_addr_d = obase_q + ADDR_W'(o_q);
                wr_data_d = activation(acc_d);
            end
            WR: begin
                acc_d  = '0;
                base_d = '0;
                k_d    = '0;
                if (o_q == nij_q - 8'd1) begin
                    state_d = FIN;
                end else begin
                    o_d       = o_q + 8'd1;
                    state_d   = RD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(o_d);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        active_d = (state_d == RD) || (state_d == DRAIN) || (state_d == WR);
        done_d   = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            nij_q     <= '0;
            kij_q     <= '0;
            obase_q   <= '0;
            o_q       <= '0;
            k_q       <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nij_q     <= nij_d;
            kij_q     <= kij_d;
            obase_q   <= obase_d;
            o_q       <= o_d;
            k_q       <= k_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign psum_rd_en   = rd_en_q;
    assign psum_rd_addr = rd_addr_q;
    assign out_wr_en    = wr_en_q;
    assign out_wr_addr  = wr_addr_q;
    assign out_wr_data  = wr_data_q;
    assign sfu_active   = active_q;
    assign sfu_done     = done_q;

endmodule

// File: tb/tb_sfu_psum_accumulator.sv
// Bench for sfu_psum_accumulator: PSUM SRAM model, output monitor and a plain-arithmetic reference model.
module tb_sfu_psum_accumulator;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sfu_start;
    logic [7:0]    num_nij, num_kij;
    logic [AW-1:0] out_base_addr;
    logic          psum_rd_en;
    logic [AW-1:0] psum_rd_addr;
    logic [DW-1:0] psum_rd_data = '0;
    logic          out_wr_en;
    logic [AW-1:0] out_wr_addr;
    logic [DW-1:0] out_wr_data;
    logic          sfu_active, sfu_done;

    sfu_psum_accumulator #(.col(COL), .psum_bw(BW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .sfu_start(sfu_start),
        .num_nij(num_nij), .num_kij(num_kij), .out_base_addr(out_base_addr),
        .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .sfu_active(sfu_active), .sfu_done(sfu_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int done_cnt, done_cyc, act_cnt, bad_cnt;

    always @(negedge clk) begin
        if (psum_rd_en) rd_q.push_back(psum_rd_addr);
        if (out_wr_en) begin
            wa_q.push_back(out_wr_addr);
            wd_q.push_back(out_wr_data);
        end
        if (sfu_active) act_cnt++;
        if (sfu_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (sfu_active) bad_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_rd_en"},   DW'(psum_rd_en),   '0);
        check({pfx, "_rd_addr"}, DW'(psum_rd_addr), '0);
        check({pfx, "_wr_en"},   DW'(out_wr_en),    '0);
        check({pfx, "_wr_addr"}, DW'(out_wr_addr),  '0);
        check({pfx, "_wr_data"}, out_wr_data,       '0);
        check({pfx, "_active"},  DW'(sfu_active),   '0);
        check({pfx, "_done"},    DW'(sfu_done),     '0);
    endtask

    // Reference: output o is the lane-wise sum over k of word (k*nij + o) mod DEPTH.
    function automatic logic [DW-1:0] model_out(input int nij, input int kij, input int o);
        logic [DW-1:0]        r;
        logic signed [BW-1:0] w;
        int                   s;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            s = 0;
            for (int k = 0; k < kij; k++) begin
                w = mem[(k * nij + o) % DEPTH][l*BW +: BW];
                s += int'(w);
            end
            w = BW'(s);
`ifdef SFU_RELU_EN
            if (w < 0) w = '0;
`endif
            r[l*BW +: BW] = w;
        end
        return r;
    endfunction

    task automatic clear_mon();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0; act_cnt = 0; bad_cnt = 0; done_cyc = 0;
    endtask

    task automatic run(input string nm, input int nij, input int kij, input int base, input int restart_at);
        int start_cyc, budget, busy, nrd, i;
        clear_mon();
        @(negedge clk);
        num_nij = 8'(nij); num_kij = 8'(kij); out_base_addr = AW'(base);
        sfu_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        sfu_start = 1'b0;
        num_nij = 8'($urandom); num_kij = 8'($urandom); out_base_addr = AW'($urandom);
        busy   = (nij == 0 || kij == 0) ? 0 : nij * (kij + 2);
        budget = busy + 10;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk);
            sfu_start = (i == restart_at);
            i++;
        end
        sfu_start = 1'b0;
        check({nm, "_timeout"}, DW'(done_cnt != 0), DW'(1));
        repeat (busy + 5) @(negedge clk);
        check({nm, "_done_cnt"}, DW'(done_cnt), DW'(1));
        check({nm, "_latency"},  DW'(done_cyc - start_cyc), DW'(busy + 1));
        check({nm, "_act_cyc"},  DW'(act_cnt), DW'(busy));
        check({nm, "_act_done"}, DW'(bad_cnt), '0);
        nrd = (busy == 0) ? 0 : nij * kij;
        check({nm, "_n_rd"}, DW'(rd_q.size()), DW'(nrd));
        for (int r = 0; r < nrd && r < rd_q.size(); r++)
            check($sformatf("%s_rd%0d", nm, r), DW'(rd_q[r]),
                  DW'(((r % kij) * nij + r / kij) % DEPTH));
        check({nm, "_n_wr"}, DW'(wa_q.size()), DW'((busy == 0) ? 0 : nij));
        for (int o = 0; o < wa_q.size() && busy != 0 && o < nij; o++) begin
            check($sformatf("%s_wa%0d", nm, o), DW'(wa_q[o]), DW'((base + o) % DEPTH));
            check($sformatf("%s_wd%0d", nm, o), wd_q[o], model_out(nij, kij, o));
        end
    endtask

    task automatic fill_rand();
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < COL; l++) mem[a][l*BW +: BW] = BW'($urandom);
    endtask

    logic [BW-1:0] exp_l0;
    logic [BW-1:0] lane_v;

    initial begin
        reset = 1'b1; sfu_start = 1'b0; num_nij = '0; num_kij = '0; out_base_addr = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Every lane of word a holds a.
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < COL; l++) mem[a][l*BW +: BW] = BW'(a);
        run("t1", 4, 3, 100, -1);
        for (int o = 0; o < 4 && o < wd_q.size(); o++) begin
            lane_v = wd_q[o][BW +: BW];
            check($sformatf("t1_lane_o%0d", o), DW'(lane_v), DW'(12 + 3 * o));
        end

        // Lane 0 negative, lane 1 positive, two kij blocks.
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        mem[0][0 +: BW] = 16'hFFFB; mem[0][BW +: BW] = 16'd5;
        mem[1][0 +: BW] = 16'hFFFB; mem[1][BW +: BW] = 16'd5;
        run("relu", 1, 2, 7, -1);
`ifdef SFU_RELU_EN
        exp_l0 = 16'h0000;
`else
        exp_l0 = 16'hFFF6;
`endif
        if (wd_q.size() > 0) begin
            lane_v = wd_q[0][0 +: BW];
            check("relu_lane0", DW'(lane_v), DW'(exp_l0));
            lane_v = wd_q[0][BW +: BW];
            check("relu_lane1", DW'(lane_v), DW'(16'd10));
        end

        // Overflow wraps.
        for (int l = 0; l < COL; l++) begin
            mem[0][l*BW +: BW] = 16'h7FFF;
            mem[1][l*BW +: BW] = 16'h7FFF;
        end
        run("ovf", 1, 2, 2047, -1);
`ifdef SFU_RELU_EN
        exp_l0 = 16'h0000;
`else
        exp_l0 = 16'hFFFE;
`endif
        if (wd_q.size() > 0) begin
            lane_v = wd_q[0][3*BW +: BW];
            check("ovf_lane3", DW'(lane_v), DW'(exp_l0));
        end

        run("kij0", 3, 0, 5, -1);
        run("nij0", 0, 4, 5, -1);

        fill_rand();
        run("restart", 2, 2, 300, 2);

        // Abort during the read phase of the second output.
        clear_mon();
        @(negedge clk);
        num_nij = 8'd2; num_kij = 8'd3; out_base_addr = 11'd40; sfu_start = 1'b1;
        @(negedge clk);
        sfu_start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_in_rd", DW'(psum_rd_en), DW'(1));
        check("abort_wr_before", DW'(wa_q.size()), DW'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        repeat (10) @(negedge clk);
        check("abort_no_done", DW'(done_cnt), '0);
        check("abort_wr_after", DW'(wa_q.size()), DW'(1));
        run("rerun", 2, 3, 40, -1);

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run($sformatf("rnd%0d", t), int'($urandom_range(1, 8)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, DEPTH - 1)), -1);
        end
        fill_rand();
        run("wrap", 200, 12, 2040, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
